// File: rtl/sdr_req_arbiter.sv
// Two-port SDRAM request arbiter with refresh scheduling.
// Picks refresh or a host request and hands one command at a time to the command FSM.
module sdr_req_arbiter #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned REF_INTERVAL = 390,
  parameter int unsigned REF_URGENT   = 4,
  parameter int unsigned REF_MAX      = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              init_done,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_src,
  input  logic              cmd_ready,
  input  logic              cmd_done,
  output logic [3:0]        ref_debt,
  output logic              ref_overflow
);

  localparam int unsigned TMR_W  = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int unsigned DEBT_W = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam logic [1:0] OP_READA  = 2'b00;
  localparam logic [1:0] OP_WRITEA = 2'b01;
  localparam logic [1:0] OP_REF    = 2'b10;

  logic [1:0]        state, state_d;
  logic [TMR_W-1:0]  ref_timer;
  logic              rr_last, rr_last_d;
  logic              cmd_valid_d;
  logic [1:0]        cmd_op_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic              cmd_src_d;
  logic              req0_ready_d, req1_ready_d;
  logic              ref_tick, ref_accept, host_pick, any_host;

  assign ref_tick   = init_done && (ref_timer == TMR_W'(REF_INTERVAL - 1));
  assign ref_accept = cmd_valid && cmd_ready && (cmd_op == OP_REF);
  assign any_host   = req0_valid || req1_valid;
  // With both ports requesting, the one not granted last wins
  assign host_pick  = (req0_valid && req1_valid) ? ~rr_last : req1_valid;

  // Refresh interval timer and outstanding refresh debt
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ref_timer    <= '0;
      ref_debt     <= '0;
      ref_overflow <= 1'b0;
    end else if (!init_done) begin
      ref_timer <= '0;
      ref_debt  <= '0;
    end else begin
      ref_timer <= ref_tick ? '0 : ref_timer + TMR_W'(1);
      if (ref_tick && !ref_accept) begin
        if (ref_debt == DEBT_W'(REF_MAX)) ref_overflow <= 1'b1;
        else                              ref_debt     <= ref_debt + DEBT_W'(1);
      end else if (ref_accept && !ref_tick && (ref_debt != '0)) begin
        ref_debt <= ref_debt - DEBT_W'(1);
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d      = state;
    cmd_valid_d  = cmd_valid;
    cmd_op_d     = cmd_op;
    cmd_addr_d   = cmd_addr;
    cmd_src_d    = cmd_src;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    rr_last_d    = rr_last;
    case (state)
      ST_IDLE: begin
        if (init_done) begin
          if ((ref_debt >= DEBT_W'(REF_URGENT)) || (!any_host && (ref_debt != '0))) begin
            state_d     = ST_ISSUE;
            cmd_valid_d = 1'b1;
            cmd_op_d    = OP_REF;
            cmd_addr_d  = '1;
            cmd_src_d   = 1'b0;
          end else if (any_host) begin
            state_d      = ST_ISSUE;
            cmd_valid_d  = 1'b1;
            cmd_op_d     = (host_pick ? req1_write : req0_write) ? OP_WRITEA : OP_READA;
            cmd_addr_d   = host_pick ? req1_addr : req0_addr;
            cmd_src_d    = host_pick;
            req0_ready_d = ~host_pick;
            req1_ready_d = host_pick;
            rr_last_d    = host_pick;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d     = ST_WAIT_DONE;
          cmd_valid_d = 1'b0;
        end
      end
      ST_WAIT_DONE: begin
        if (cmd_done) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state      <= ST_IDLE;
      cmd_valid  <= 1'b0;
      cmd_op     <= OP_READA;
      cmd_addr   <= '0;
      cmd_src    <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rr_last    <= 1'b1;
    end else begin
      state      <= state_d;
      cmd_valid  <= cmd_valid_d;
      cmd_op     <= cmd_op_d;
      cmd_addr   <= cmd_addr_d;
      cmd_src    <= cmd_src_d;
      req0_ready <= req0_ready_d;
      req1_ready <= req1_ready_d;
      rr_last    <= rr_last_d;
    end
  end

endmodule

// File: tb/tb_sdr_req_arbiter.sv
// Directed bench for sdr_req_arbiter: scoreboard of expected commands popped on each
// command acceptance, plus directed checks for refresh pressure and reset.
module tb_sdr_req_arbiter;

  localparam int unsigned ADDR_W       = 20;
  localparam int unsigned REF_INTERVAL = 10;
  localparam int unsigned REF_URGENT   = 4;
  localparam int unsigned REF_MAX      = 8;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_REF = 2'b10;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_ONES = '1;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic              src;
  } cmd_t;

  logic              pclk = 1'b0;
  logic              presetn, init_done;
  logic              req0_valid, req0_write, req1_valid, req1_write;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic              req0_ready, req1_ready;
  logic              cmd_valid, cmd_src, cmd_ready, cmd_done;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        ref_debt;
  logic              ref_overflow;

  cmd_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   sb_en = 1'b0;

  always #5 pclk = ~pclk;

  sdr_req_arbiter #(
    .ADDR_W(ADDR_W), .REF_INTERVAL(REF_INTERVAL),
    .REF_URGENT(REF_URGENT), .REF_MAX(REF_MAX)
  ) dut (
    .pclk(pclk), .presetn(presetn), .init_done(init_done),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_src(cmd_src),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .ref_debt(ref_debt), .ref_overflow(ref_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted command must match the oldest expectation
  always @(negedge pclk) begin
    cmd_t e;
    logic [1:0] exp_rdy;
    if (sb_en && presetn === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_cmd", 32'({cmd_op, cmd_addr, cmd_src}), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_cmd", 32'({cmd_op, cmd_addr, cmd_src}), 32'(e));
        exp_rdy = (e.op == OP_REF) ? 2'b00 : (e.src ? 2'b10 : 2'b01);
        check("sb_ready_pulse", 32'({req1_ready, req0_ready}), 32'(exp_rdy));
      end
    end
  end

  task automatic do_reset();
    @(negedge pclk);
    presetn = 1'b0; init_done = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
  endtask

  task automatic drive_port(input bit port, input logic v, input logic w, input logic [ADDR_W-1:0] a);
    if (port) begin req1_valid = v; req1_write = w; req1_addr = a; end
    else      begin req0_valid = v; req0_write = w; req0_addr = a; end
  endtask

  task automatic wait_ready(input bit port);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge pclk);
      cyc++;
      seen = port ? req1_ready : req0_ready;
    end
    if (!seen) check(port ? "ready1_timeout" : "ready0_timeout", 32'(0), 32'(1));
  endtask

  task automatic host_stream(input bit port, input int n, input logic [ADDR_W-1:0] base, input bit wr);
    for (int k = 0; k < n; k++) begin
      drive_port(port, 1'b1, wr, base + ADDR_W'(k));
      wait_ready(port);
    end
    drive_port(port, 1'b0, 1'b0, '0);
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge pclk);
      #1;
      cyc++;
    end
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(cmd_valid), 32'(0));
    check({tag, "_op"},    32'(cmd_op),    32'(0));
    check({tag, "_addr"},  32'(cmd_addr),  32'(0));
    check({tag, "_src"},   32'(cmd_src),   32'(0));
    check({tag, "_rdy"},   32'({req1_ready, req0_ready}), 32'(0));
    check({tag, "_debt"},  32'(ref_debt),  32'(0));
    check({tag, "_ovf"},   32'(ref_overflow), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    presetn = 1'b0; init_done = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0;

    // Reset values
    repeat (3) @(negedge pclk);
    check_reset_outputs("rst");

    // Single read then idle refreshes, each tick paid back
    presetn = 1'b1; init_done = 1'b1; cmd_ready = 1'b1; cmd_done = 1'b1; sb_en = 1'b1;
    exp_q.push_back('{OP_RD, ADDR_W'(20'h00123), 1'b0});
    for (int i = 0; i < 3; i++) exp_q.push_back('{OP_REF, ADDR_ONES, 1'b0});
    drive_port(1'b0, 1'b1, 1'b0, ADDR_W'(20'h00123));
    wait_ready(1'b0);
    check("rd_first_issue_valid", 32'(cmd_valid), 32'(1));
    drive_port(1'b0, 1'b0, 1'b0, '0);
    @(negedge pclk);
    check("rd_wait_state", 32'(dut.state), 32'(ST_WAIT));
    check("rd_wait_valid", 32'(cmd_valid), 32'(0));
    @(negedge pclk);
    check("rd_idle_after_3", 32'(dut.state), 32'(ST_IDLE));
    drain("ref_idle_drain");
    repeat (2) @(negedge pclk);
    check("ref_debt_paid", 32'(ref_debt), 32'(0));
    check("ref_no_ovf", 32'(ref_overflow), 32'(0));

    // Round robin with both ports always requesting
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{OP_RD, ADDR_W'(20'h01000 + k), 1'b0});
      exp_q.push_back('{OP_WR, ADDR_W'(20'h02000 + k), 1'b1});
    end
    init_done = 1'b1;
    fork
      host_stream(1'b0, 3, ADDR_W'(20'h01000), 1'b0);
      host_stream(1'b1, 3, ADDR_W'(20'h02000), 1'b1);
    join
    init_done = 1'b0;
    drain("rr_drain");

    // Urgent refresh preempts saturating hosts
    sb_en = 1'b0;
    do_reset();
    init_done = 1'b1;
    found = 1'b0;
    fork
      host_stream(1'b0, 20, ADDR_W'(20'h03000), 1'b0);
      host_stream(1'b1, 20, ADDR_W'(20'h04000), 1'b1);
      begin
        for (int c = 0; c < 100 && !found; c++) begin
          @(negedge pclk);
          if (dut.state == ST_IDLE && ref_debt >= 4'd4 && req0_valid && req1_valid) found = 1'b1;
        end
        check("urgent_seen", 32'(found), 32'(1));
        if (found) begin
          check("urgent_debt", 32'(ref_debt), 32'(4));
          @(negedge pclk);
          check("urgent_cmd", 32'({cmd_valid, cmd_op, cmd_addr, cmd_src}),
                32'({1'b1, OP_REF, ADDR_ONES, 1'b0}));
          check("urgent_no_ready", 32'({req1_ready, req0_ready}), 32'(0));
        end
      end
    join
    init_done = 1'b0;

    // Refresh stalled by cmd_ready low: debt saturates and overflow sticks
    do_reset();
    cmd_ready = 1'b0;
    init_done = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge pclk);
      found = cmd_valid;
    end
    check("stall_issue_seen", 32'(found), 32'(1));
    for (int c = 0; c < 95; c++) begin
      @(negedge pclk);
      check("stall_cmd_hold", 32'({cmd_valid, cmd_op, cmd_addr}), 32'({1'b1, OP_REF, ADDR_ONES}));
    end
    check("stall_debt_sat", 32'(ref_debt), 32'(REF_MAX));
    check("stall_ovf", 32'(ref_overflow), 32'(1));
    cmd_ready = 1'b1;
    @(negedge pclk);
    check("stall_debt_dec", 32'(ref_debt), 32'(7));
    check("stall_ovf_sticky", 32'(ref_overflow), 32'(1));
    init_done = 1'b0;

    // Reset while waiting for done, stray done afterwards
    do_reset();
    sb_en = 1'b1; cmd_ready = 1'b1; cmd_done = 1'b0; init_done = 1'b1;
    exp_q.push_back('{OP_WR, ADDR_W'(20'hABCDE), 1'b1});
    drive_port(1'b1, 1'b1, 1'b1, ADDR_W'(20'hABCDE));
    wait_ready(1'b1);
    drive_port(1'b1, 1'b0, 1'b0, '0);
    @(negedge pclk);
    check("wd_state", 32'(dut.state), 32'(ST_WAIT));
    check("wd_valid_low", 32'(cmd_valid), 32'(0));
    presetn = 1'b0;
    @(negedge pclk);
    check_reset_outputs("wd_rst");
    check("wd_rst_state", 32'(dut.state), 32'(ST_IDLE));
    presetn = 1'b1; init_done = 1'b0; cmd_done = 1'b1;
    drive_port(1'b0, 1'b1, 1'b0, ADDR_W'(20'h00055));
    repeat (15) @(negedge pclk);
    check("noinit_state", 32'(dut.state), 32'(ST_IDLE));
    check("noinit_valid", 32'(cmd_valid), 32'(0));
    check("noinit_ready", 32'({req1_ready, req0_ready}), 32'(0));
    check("noinit_debt", 32'(ref_debt), 32'(0));
    drive_port(1'b0, 1'b0, 1'b0, '0);
    check("final_sb_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdr_req_arbiter.md
SDR_REQ_ARBITER -- requirements
Module: sdr_req_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 20, width of a host address (row, bank and column fields, same packing as paddr).
REQ-002 Parameter: REF_INTERVAL, default 390, pclk cycles between refresh ticks.
REQ-003 Parameter: REF_URGENT, default 4, refresh debt at which refresh preempts host requests.
REQ-004 Parameter: REF_MAX, default 8, refresh debt saturation value.
REQ-005 pclk  in  1  single clock, all logic on rising edge.
REQ-006 presetn  in  1  reset, synchronous, active-low.
REQ-007 init_done  in  1  SDRAM init sequence complete; level.
REQ-008 req0_valid / req1_valid  in  1  host port n request.
REQ-009 req0_write / req1_write  in  1  1 = write, 0 = read.
REQ-010 req0_addr / req1_addr  in  ADDR_W  host address.
REQ-011 req0_ready / req1_ready  out  1  one-cycle accept pulse.
REQ-012 cmd_valid  out  1  command presented to command FSM.
REQ-013 cmd_op  out  2  00 READA, 01 WRITEA, 10 AUTO_REFRESH, 11 unused.
REQ-014 cmd_addr  out  ADDR_W  captured address; all-ones for refresh.
REQ-015 cmd_src  out  1  granted port index; 0 for refresh.
REQ-016 cmd_ready  in  1  command FSM accepts cmd_valid this cycle.
REQ-017 cmd_done  in  1  one-cycle pulse, accepted command finished.
REQ-018 ref_debt  out  4  outstanding refresh count.
REQ-019 ref_overflow  out  1  sticky, refresh tick lost at saturation.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT_DONE.
REQ-021 While init_done=0: SHALL stay in IDLE, hold the refresh timer and ref_debt at 0, issue no grants.
REQ-022 Refresh timer SHALL count 0..REF_INTERVAL-1 while init_done=1 and wrap; each wrap SHALL be a tick.
REQ-023 Tick SHALL increment ref_debt; a refresh acceptance (cmd_valid & cmd_ready & cmd_op=10) SHALL decrement it; both in one cycle SHALL leave it unchanged.
REQ-024 Tick with ref_debt=REF_MAX and no simultaneous decrement SHALL leave ref_debt at REF_MAX and set ref_overflow until reset.
REQ-025 IDLE selection, priority order: (a) refresh if ref_debt>=REF_URGENT; (b) a host port if any valid; (c) refresh if ref_debt>0; else remain IDLE.
REQ-026 Host choice SHALL be round-robin: with both valid, the port not granted last wins; pointer updates only on a host grant; after reset port 0 wins first.
REQ-027 On selection at edge N, SHALL capture op/addr/src and move to ISSUE; in cycle N+1 cmd_valid=1 and, for a host grant, the granted reqN_ready=1 for that cycle only.
REQ-028 Hosts SHALL hold valid/write/addr stable until ready; arbiter samples them only in IDLE.
REQ-029 In ISSUE, cmd_valid, cmd_op, cmd_addr, cmd_src SHALL stay stable until cmd_ready=1; then next state WAIT_DONE with cmd_valid=0.
REQ-030 In WAIT_DONE, cmd_done=1 SHALL return to IDLE; cmd_done outside WAIT_DONE SHALL be ignored.
REQ-031 Minimum spacing: one command per 3 cycles (IDLE, ISSUE, WAIT_DONE) when cmd_ready and cmd_done each arrive in the earliest cycle.
REQ-032 init_done falling mid-operation SHALL not abort ISSUE/WAIT_DONE; the current command completes, then REQ-021 applies.
REQ-033 At most one ready pulse per cycle; never both ports.

Reset
REQ-034 presetn=0 at an edge SHALL force: state IDLE, cmd_valid=0, cmd_op=00, cmd_addr=0, cmd_src=0, req0_ready=req1_ready=0, ref_debt=0, ref_overflow=0, timer=0, round-robin pointer to port 1 (port 0 next), regardless of current state.

Verification
REQ-035 init_done=1, req0 read addr 0x00123, cmd_ready and cmd_done immediate -> cmd_op=00, cmd_addr=0x00123, cmd_src=0, req0_ready one pulse in the cmd_valid first cycle, back to IDLE after 3 cycles.
REQ-036 Both ports valid continuously -> grants alternate 0,1,0,1; no port granted twice consecutively.
REQ-037 REF_INTERVAL=10, ports idle -> refresh issued after each tick, ref_debt returns to 0.
REQ-038 Ports saturating, REF_INTERVAL=10 -> ref_debt climbs to 4, next IDLE selection is refresh despite valid ports.
REQ-039 cmd_ready held 0 for 40 cycles with REF_INTERVAL=4 -> ref_debt saturates at 8, ref_overflow=1; cmd_valid/addr stable throughout.
REQ-040 presetn=0 in WAIT_DONE -> next cycle all outputs at REQ-034 values; later cmd_done ignored.
